// File: rtl/ahb_burst_master.sv
// rtl/ahb_burst_master.sv - AHB-Lite burst master turning one command into a pipelined burst
module ahb_burst_master (
  input  logic        hclk,
  input  logic        hrst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_burst,
  input  logic [2:0]  cmd_size,
  input  logic [3:0]  cmd_len,
  input  logic [31:0] wr_data,
  output logic        wr_pop,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        done,
  output logic        err,
  output logic [1:0]  htrans,
  output logic [31:0] haddr,
  output logic [2:0]  hburst,
  output logic [2:0]  hsize,
  output logic        hwrite,
  output logic [31:0] hwdata,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata
);

  typedef enum logic [1:0] {IDLE, BUS, LAST} state_t;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  state_t      state, state_n;
  logic [3:0]  beats_left;   // address phases still to issue after the current one
  logic        dphase;       // a data phase is outstanding on the bus
  logic        err_seen;
  logic        accept;
  logic        err_hit;
  logic [2:0]  sz_c;
  logic [31:0] addr_c;
  logic [3:0]  beats_c;
  logic [31:0] incr;
  logic [31:0] wrap_mask;
  logic [31:0] addr_sum;
  logic [31:0] addr_next;
  logic        is_wrap;

  assign cmd_ready = (state == IDLE);
  // A beat is taken by the slave whenever an active transfer meets hready.
  assign accept    = (state == BUS) && htrans[1] && hready;
  // First cycle of a two-cycle error response; the remaining beats are dropped here.
  assign err_hit   = dphase && !hready && (hresp != 2'b00);
  // The FWFT word is consumed on the same edge that hwdata captures it.
  assign wr_pop    = accept && hwrite;

  // Command decode: clamp size, align start address, derive beat count minus one.
  always_comb begin
    sz_c   = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
    addr_c = cmd_addr;
    if (sz_c == 3'd1) addr_c[0] = 1'b0;
    if (sz_c == 3'd2) addr_c[1:0] = 2'b00;
    case (cmd_burst[2:1])
      2'b00:   beats_c = cmd_burst[0] ? (cmd_len - 4'd1) : 4'd0;
      2'b01:   beats_c = 4'd3;
      2'b10:   beats_c = 4'd7;
      default: beats_c = 4'd15;
    endcase
  end

  // Next beat address: linear increment, folded into the wrap block for WRAPn.
  always_comb begin
    incr    = 32'd1 << hsize;
    is_wrap = !hburst[0] && (hburst[2:1] != 2'b00);
    case (hburst[2:1])
      2'b01:   wrap_mask = (incr << 2) - 32'd1;
      2'b10:   wrap_mask = (incr << 3) - 32'd1;
      default: wrap_mask = (incr << 4) - 32'd1;
    endcase
    addr_sum  = haddr + incr;
    addr_next = is_wrap ? ((haddr & ~wrap_mask) | (addr_sum & wrap_mask)) : addr_sum;
  end

  // State register.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) state <= IDLE;
    else         state <= state_n;
  end

  // Next-state decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cmd_valid) state_n = BUS;
      BUS:     if (err_hit || (accept && (beats_left == 4'd0))) state_n = LAST;
      LAST:    if (hready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus outputs, beat bookkeeping, read return and completion.
  always_ff @(posedge hclk or negedge hrst_n) begin
    if (!hrst_n) begin
      htrans     <= HT_IDLE;
      haddr      <= 32'd0;
      hburst     <= 3'd0;
      hsize      <= 3'd0;
      hwrite     <= 1'b0;
      hwdata     <= 32'd0;
      rd_data    <= 32'd0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      beats_left <= 4'd0;
      dphase     <= 1'b0;
      err_seen   <= 1'b0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      if (hready) dphase <= accept;
      if (hready && dphase && !hwrite && (hresp == 2'b00)) begin
        rd_valid <= 1'b1;
        rd_data  <= hrdata;
      end
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            haddr      <= addr_c;
            hburst     <= cmd_burst;
            hsize      <= sz_c;
            hwrite     <= cmd_write;
            htrans     <= HT_NONSEQ;
            beats_left <= beats_c;
            err_seen   <= 1'b0;
          end
        end
        BUS: begin
          if (err_hit) begin
            htrans   <= HT_IDLE;
            err_seen <= 1'b1;
          end else if (accept) begin
            if (hwrite) hwdata <= wr_data;
            if (beats_left == 4'd0) begin
              htrans <= HT_IDLE;
            end else begin
              haddr      <= addr_next;
              // Incrementing bursts restart with NONSEQ when they cross into a new 1 KB page.
              htrans     <= (!is_wrap && (addr_next[9:0] == 10'd0)) ? HT_NONSEQ : HT_SEQ;
              beats_left <= beats_left - 4'd1;
            end
          end
        end
        LAST: begin
          if (err_hit) err_seen <= 1'b1;
          if (hready) begin
            done <= 1'b1;
            err  <= err_seen || (hresp != 2'b00);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_burst_master.sv
// tb/tb_ahb_burst_master.sv - randomized self-checking bench for ahb_burst_master
module tb_ahb_burst_master;

  logic        hclk = 1'b0;
  logic        hrst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [2:0]  cmd_burst;
  logic [2:0]  cmd_size;
  logic [3:0]  cmd_len;
  logic [31:0] wr_data;
  logic        wr_pop;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [2:0]  hburst;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  ahb_burst_master dut (
    .hclk(hclk), .hrst_n(hrst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop), .rd_data(rd_data), .rd_valid(rd_valid),
    .done(done), .err(err),
    .htrans(htrans), .haddr(haddr), .hburst(hburst), .hsize(hsize),
    .hwrite(hwrite), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rdata_of(input logic [31:0] a);
    return (a ^ 32'h5A5A_C3C3) + 32'h0101_0101;
  endfunction

  // Slave/monitor state for the burst in progress.
  int          cyc = 0;
  bit          cmd_pending = 0;
  int          t_acc, pops, low_cnt, err_cycle, done_cyc, dp_idx, wait_left, err_beat;
  bit          dp_valid, done_err, wr_cmd;
  logic [31:0] dp_addr, wr_base;
  logic [2:0]  exp_size, exp_burst;
  int          waits[16];
  logic [31:0] acc_addr[$];
  logic [1:0]  acc_trans[$];
  logic [31:0] rd_q[$];
  bit          prev_hready = 1, prev_err1 = 0;
  logic [31:0] prev_haddr, prev_hwdata;
  logic [1:0]  prev_htrans;

  // One bus cycle: drive slave response at negedge, observe 1 ns later.
  task automatic step();
    bit err1;
    @(negedge hclk);
    cyc++;
    err1 = 0;
    cmd_valid = cmd_pending;
    hrdata = $urandom;
    if (dp_valid && dp_idx == err_beat) begin
      if (err_cycle == 0) begin
        hready = 0; hresp = 2'b01; err_cycle = cyc; low_cnt++; err1 = 1;
      end else begin
        hready = 1; hresp = 2'b01;
      end
    end else if (dp_valid && wait_left > 0) begin
      hready = 0; hresp = 2'b00; wait_left--; low_cnt++;
    end else begin
      hready = 1; hresp = 2'b00;
      if (dp_valid) hrdata = rdata_of(dp_addr);
    end
    wr_data = wr_base + 32'(pops);
    #1;
    if (cmd_valid && cmd_ready) begin
      t_acc = cyc;
      cmd_pending = 0;
    end
    if (err_cycle != 0 && cyc == err_cycle + 1) check("htrans_idle_after_err", 32'(htrans), 32'd0);
    if (!prev_hready && !prev_err1) begin
      check("stall_haddr", haddr, prev_haddr);
      check("stall_htrans", 32'(htrans), 32'(prev_htrans));
      check("stall_hwdata", hwdata, prev_hwdata);
    end
    if (!hready) check("stall_no_pop", 32'(wr_pop), 32'd0);
    if (htrans[1] && hready) begin
      acc_addr.push_back(haddr);
      acc_trans.push_back(htrans);
    end
    if (wr_pop) pops++;
    if (rd_valid) rd_q.push_back(rd_data);
    if (dp_valid && hready && wr_cmd && dp_idx != err_beat)
      check("hwdata", hwdata, wr_base + 32'(dp_idx));
    if (done) begin
      done_cyc = cyc;
      done_err = err;
      check("cmd_ready_at_done", 32'(cmd_ready), 32'd1);
      check("hsize_held", 32'(hsize), 32'(exp_size));
      check("hburst_held", 32'(hburst), 32'(exp_burst));
    end
    prev_hready = hready;
    prev_err1   = err1;
    prev_haddr  = haddr;
    prev_htrans = htrans;
    prev_hwdata = hwdata;
    if (hready) begin
      if (dp_valid) dp_idx++;
      dp_valid = htrans[1];
      dp_addr  = haddr;
      if (htrans[1]) wait_left = (dp_idx < 16) ? waits[dp_idx] : 0;
    end
  endtask

  // Issue one command and compare the observed burst with the arithmetic model.
  // eb: erroring beat (-1 none, -2 random); sb/sn: directed stall beat/length; maxw: random waits.
  task automatic run_burst(input string name, input bit wr, input logic [31:0] a,
                           input logic [2:0] b, input logic [2:0] s, input logic [3:0] l,
                           input logic [31:0] wb, input int eb_in, input int sb, input int sn,
                           input int maxw);
    int          n, sc, eb, exp_acc, exp_rd;
    logic [31:0] inc, al, blk, base;
    logic [31:0] ea[16];
    logic [1:0]  et[16];
    logic [31:0] ai;
    bit          wrap;
    sc   = (s > 3'd2) ? 2 : int'(s);
    inc  = 32'd1 << sc;
    al   = a & ~(inc - 32'd1);
    case (b)
      3'd0:       n = 1;
      3'd1:       n = (l == 4'd0) ? 16 : int'(l);
      3'd2, 3'd3: n = 4;
      3'd4, 3'd5: n = 8;
      default:    n = 16;
    endcase
    wrap = (b == 3'd2) || (b == 3'd4) || (b == 3'd6);
    blk  = 32'(n) * inc;
    base = al - (al % blk);
    for (int i = 0; i < n; i++) begin
      if (wrap) ai = base + (((al - base) + 32'(i) * inc) % blk);
      else      ai = al + 32'(i) * inc;
      ea[i] = ai;
      et[i] = (i == 0 || (!wrap && (ai % 32'd1024) == 32'd0)) ? 2'b10 : 2'b11;
    end
    eb = eb_in;
    if (eb == -2) eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, n - 1)) : -1;
    for (int k = 0; k < 16; k++) waits[k] = (maxw > 0) ? int'($urandom_range(0, maxw)) : 0;
    if (sb >= 0) waits[sb] = sn;
    if (eb >= 0) waits[eb] = 0;
    err_beat  = eb;
    acc_addr.delete(); acc_trans.delete(); rd_q.delete();
    pops = 0; low_cnt = 0; err_cycle = 0; done_cyc = -1; t_acc = -1;
    dp_valid = 0; dp_idx = 0; wait_left = 0; done_err = 0;
    wr_cmd = wr; wr_base = wb;
    exp_size = 3'(sc); exp_burst = b;
    cmd_write = wr; cmd_addr = a; cmd_burst = b; cmd_size = s; cmd_len = l;
    cmd_pending = 1;
    for (int c = 0; c < 300 && done_cyc < 0; c++) step();
    check($sformatf("%s:done_seen", name), 32'(done_cyc >= 0), 32'd1);
    step();
    exp_acc = (eb >= 0) ? ((eb + 1 < n) ? eb + 1 : n) : n;
    exp_rd  = wr ? 0 : ((eb >= 0) ? eb : n);
    check($sformatf("%s:beats", name), 32'(acc_addr.size()), 32'(exp_acc));
    for (int i = 0; i < exp_acc && i < acc_addr.size(); i++) begin
      check($sformatf("%s:haddr%0d", name, i), acc_addr[i], ea[i]);
      check($sformatf("%s:htrans%0d", name, i), 32'(acc_trans[i]), 32'(et[i]));
    end
    check($sformatf("%s:wr_pops", name), 32'(pops), wr ? 32'(exp_acc) : 32'd0);
    check($sformatf("%s:rd_count", name), 32'(rd_q.size()), 32'(exp_rd));
    for (int i = 0; i < exp_rd && i < rd_q.size(); i++)
      check($sformatf("%s:rd_data%0d", name, i), rd_q[i], rdata_of(ea[i]));
    check($sformatf("%s:done_cycle", name), 32'(done_cyc), 32'(t_acc + exp_acc + 2 + low_cnt));
    check($sformatf("%s:err", name), 32'(done_err), 32'(eb >= 0));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ":htrans"},    32'(htrans), 32'd0);
    check({tag, ":haddr"},     haddr, 32'd0);
    check({tag, ":hburst"},    32'(hburst), 32'd0);
    check({tag, ":hsize"},     32'(hsize), 32'd0);
    check({tag, ":hwrite"},    32'(hwrite), 32'd0);
    check({tag, ":hwdata"},    hwdata, 32'd0);
    check({tag, ":rd_data"},   rd_data, 32'd0);
    check({tag, ":cmd_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, ":wr_pop"},    32'(wr_pop), 32'd0);
    check({tag, ":rd_valid"},  32'(rd_valid), 32'd0);
    check({tag, ":done"},      32'(done), 32'd0);
    check({tag, ":err"},       32'(err), 32'd0);
  endtask

  initial begin
    hrst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_burst = 0;
    cmd_size = 0; cmd_len = 0; wr_data = 0; hready = 1; hresp = 0; hrdata = 0;
    err_beat = -1; wr_base = 0; dp_valid = 0;
    repeat (3) @(negedge hclk);
    #1;
    check_reset_values("reset");
    @(negedge hclk);
    hrst_n = 1;

    run_burst("wrap4_rd",   1'b0, 32'h38,  3'd2, 3'd2, 4'd0, 32'h0,  -1, -1, 0, 0);
    run_burst("incr8_wr",   1'b1, 32'h100, 3'd5, 3'd0, 4'd0, 32'h11, -1, -1, 0, 0);
    run_burst("incr4_1k",   1'b0, 32'h3F8, 3'd3, 3'd2, 4'd0, 32'h0,  -1, -1, 0, 0);
    run_burst("incr4_stall",1'b1, 32'h200, 3'd3, 3'd2, 4'd0, 32'hA0, -1,  1, 3, 0);
    run_burst("incr8_err",  1'b0, 32'h400, 3'd5, 3'd2, 4'd0, 32'h0,   1, -1, 0, 0);
    run_burst("incr_len3",  1'b1, 32'h7FE, 3'd1, 3'd1, 4'd3, 32'h55, -1, -1, 0, 0);
    run_burst("wrap8_half", 1'b0, 32'h1236,3'd4, 3'd1, 4'd0, 32'h0,  -1, -1, 0, 1);

    // Reset in the middle of an INCR16 read.
    err_beat = -1; acc_addr.delete(); acc_trans.delete(); rd_q.delete();
    pops = 0; low_cnt = 0; err_cycle = 0; done_cyc = -1; dp_valid = 0; dp_idx = 0;
    wait_left = 0; wr_cmd = 0; wr_base = 0;
    for (int k = 0; k < 16; k++) waits[k] = 0;
    exp_size = 3'd2; exp_burst = 3'd7;
    cmd_write = 0; cmd_addr = 32'h800; cmd_burst = 3'd7; cmd_size = 3'd2; cmd_len = 0;
    cmd_pending = 1;
    for (int c = 0; c < 50 && acc_addr.size() < 5; c++) step();
    check("midreset:started", 32'(acc_addr.size() >= 5), 32'd1);
    #2 hrst_n = 0;
    #1;
    check_reset_values("midreset");
    cmd_pending = 0; cmd_valid = 0; dp_valid = 0; prev_hready = 1; prev_err1 = 0;
    hready = 1; hresp = 0;
    repeat (2) @(negedge hclk);
    #1;
    check("midreset:done_held", 32'(done), 32'd0);
    hrst_n = 1;
    run_burst("single_after_rst", 1'b1, 32'h1004, 3'd0, 3'd2, 4'd0, 32'hBEEF0000, -1, -1, 0, 0);

    for (int r = 0; r < 40; r++) begin
      run_burst($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), $urandom,
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                $urandom, -2, -1, 0, 2);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
